// File: rtl/bus_cpu_pkg.sv
// bus_cpu_pkg: shared types for the bus CPU core.
//   opcode_e : 4-bit instruction opcodes
//   state_e  : fetch/execute/halt sequencer states
//   instr_w  : instruction word width for a given data width
package bus_cpu_pkg;
  localparam int OPC_W = 4;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP  = 4'h0, OP_LDI = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
    OP_AND  = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_IN  = 4'h7,
    OP_OUT  = 4'h8, OP_JMP = 4'h9, OP_JC  = 4'hA, OP_JZ  = 4'hB,
    OP_ADC  = 4'hC, OP_RSD = 4'hD, OP_RSE = 4'hE, OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  function automatic int instr_w(input int data_w);
    return OPC_W + data_w;
  endfunction
endpackage

// File: rtl/bus_cpu_alu.sv
// bus_cpu_alu: combinational ALU.
//   op     : opcode being executed
//   a      : accumulator
//   b      : operand (immediate, or input port for IN)
//   cy_in  : current carry flag
//   res    : result written to the accumulator
//   cy_out : new carry (equals cy_in for ops that do not touch carry)
//   zero   : res == 0
module bus_cpu_alu
  import bus_cpu_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  opcode_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cy_in,
  output logic [DATA_W-1:0] res,
  output logic              cy_out,
  output logic              zero
);
  logic [DATA_W:0] sum;

  always_comb begin
    sum    = '0;
    res    = a;
    cy_out = cy_in;
    case (op)
      OP_LDI, OP_IN: res = b;
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        res    = sum[DATA_W-1:0];
        cy_out = sum[DATA_W];
      end
      OP_ADC: begin
        sum    = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cy_in};
        res    = sum[DATA_W-1:0];
        cy_out = sum[DATA_W];
      end
      OP_SUB: begin
        // Top bit of the widened difference is the borrow; carry means "no borrow".
        sum    = {1'b0, a} - {1'b0, b};
        res    = sum[DATA_W-1:0];
        cy_out = ~sum[DATA_W];
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      default: ;
    endcase
    zero = (res == '0);
  end
endmodule

// File: rtl/bus_cpu_core.sv
// bus_cpu_core: accumulator CPU with req/ack program fetch.
//   clk, rst     : clock, async active-low reset
//   imem_addr    : fetch address (PC), stable while imem_req is high
//   imem_req     : fetch request (FETCH state, deasserted in reset)
//   imem_ack     : fetch complete, imem_data valid (ignored outside FETCH)
//   imem_data    : {opcode, imm}
//   in_port      : sampled at the end of EXEC of IN
//   out_port     : N_OUT output registers, port p at [p*DATA_W +: DATA_W]
//   out_strobe   : one-cycle pulse aligned with each port update
//   acc, cy, zf  : accumulator and flags
//   halted       : core is in HALT
module bus_cpu_core
  import bus_cpu_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 8,
  parameter int N_OUT  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [ADDR_W-1:0]         imem_addr,
  output logic                      imem_req,
  input  logic                      imem_ack,
  input  logic [instr_w(DATA_W)-1:0] imem_data,
  input  logic [DATA_W-1:0]         in_port,
  output logic [N_OUT*DATA_W-1:0]   out_port,
  output logic [N_OUT-1:0]          out_strobe,
  output logic [DATA_W-1:0]         acc,
  output logic                      cy,
  output logic                      zf,
  output logic                      halted
);
  localparam int IW = instr_w(DATA_W);

  state_e                         state, state_nxt;
  logic   [ADDR_W-1:0]            pc, jmp_tgt;
  logic   [IW-1:0]                ir;
  opcode_e                        op;
  logic   [DATA_W-1:0]            imm, alu_b, alu_res;
  logic                           alu_cy, alu_zero, acc_we, jmp_take;
  logic   [N_OUT-1:0]             port_wr;
  logic   [N_OUT-1:0][DATA_W-1:0] port_q;

  assign op        = opcode_e'(ir[IW-1 -: OPC_W]);
  assign imm       = ir[DATA_W-1:0];
  assign imem_addr = pc;
  assign out_port  = port_q;
  assign alu_b     = (op == OP_IN) ? in_port : imm;

  bus_cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op    (op),
    .a     (acc),
    .b     (alu_b),
    .cy_in (cy),
    .res   (alu_res),
    .cy_out(alu_cy),
    .zero  (alu_zero)
  );

  // Jumps are page-relative: upper bits come from the (already incremented) PC.
  if (ADDR_W > DATA_W) begin : g_tgt_page
    assign jmp_tgt = {pc[ADDR_W-1:DATA_W], imm};
  end else begin : g_tgt_trunc
    assign jmp_tgt = imm[ADDR_W-1:0];
  end

  always_comb begin
    acc_we = op inside {OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_IN, OP_ADC};
    case (op)
      OP_JMP:  jmp_take = 1'b1;
      OP_JC:   jmp_take = cy;
      OP_JZ:   jmp_take = zf;
      default: jmp_take = 1'b0;
    endcase
  end

  // Out-of-range port numbers match no bit and are dropped.
  always_comb begin
    port_wr = '0;
    for (int p = 0; p < N_OUT; p++)
      port_wr[p] = (state == ST_EXEC) && (op == OP_OUT) && (32'(imm) == p);
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_FETCH;
    else      state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_FETCH: if (imem_ack) state_nxt = ST_EXEC;
      ST_EXEC:  state_nxt = (op == OP_HALT) ? ST_HALT : ST_FETCH;
      default:  state_nxt = ST_HALT;
    endcase
  end

  // FSM: outputs; the request drops combinationally as soon as reset asserts
  always_comb begin
    imem_req = rst && (state == ST_FETCH);
    halted   = (state == ST_HALT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc  <= '0;
      ir  <= '0;
      acc <= '0;
      cy  <= 1'b0;
      zf  <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: if (imem_ack) begin
          ir <= imem_data;
          pc <= pc + ADDR_W'(1);
        end
        ST_EXEC: begin
          if (acc_we) begin
            acc <= alu_res;
            zf  <= alu_zero;
          end
          cy <= alu_cy;
          if (jmp_take) pc <= jmp_tgt;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      port_q     <= '0;
      out_strobe <= '0;
    end else begin
      out_strobe <= port_wr;
      for (int p = 0; p < N_OUT; p++)
        if (port_wr[p]) port_q[p] <= acc;
    end
  end
endmodule

// File: tb/tb_bus_cpu_core.sv
module tb_bus_cpu_core;
  localparam int DW = 4, AW = 8, NO = 2;
  localparam int PF = 0, PE = 1, PH = 2;  // model phases

  logic              clk = 1'b0, rst = 1'b0;
  logic [AW-1:0]     imem_addr;
  logic              imem_req, imem_ack;
  logic [DW+3:0]     imem_data;
  logic [DW-1:0]     in_port, acc;
  logic [NO*DW-1:0]  out_port;
  logic [NO-1:0]     out_strobe;
  logic              cy, zf, halted;

  bus_cpu_core #(.DATA_W(DW), .ADDR_W(AW), .N_OUT(NO)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_ack(imem_ack), .imem_data(imem_data), .in_port(in_port),
    .out_port(out_port), .out_strobe(out_strobe), .acc(acc), .cy(cy),
    .zf(zf), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  logic [7:0] mem [256];
  int wait_mode = 0, wait_cnt = 0;
  int st_cnt [NO];
  int trace [$];

  // Instruction-level model of the architectural state
  int m_pc, m_acc, m_cy, m_zf, m_phase, m_ir;
  int m_port [NO];
  logic [NO-1:0] m_strobe;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int next_wait();
    return (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
  endfunction

  task automatic m_reset();
    m_pc = 0; m_acc = 0; m_cy = 0; m_zf = 0; m_phase = PF; m_ir = 0;
    foreach (m_port[p]) m_port[p] = 0;
    m_strobe = '0;
    wait_cnt = next_wait();
  endtask

  task automatic m_exec();
    int op, imm, s;
    op  = m_ir >> 4;
    imm = m_ir & 15;
    m_phase = PF;
    case (op)
      1: m_acc = imm;
      2: begin s = m_acc + imm; m_cy = int'(s > 15); m_acc = s & 15; end
      3: begin m_cy = int'(m_acc >= imm); m_acc = (m_acc - imm) & 15; end
      4: m_acc = m_acc & imm;
      5: m_acc = m_acc | imm;
      6: m_acc = m_acc ^ imm;
      7: m_acc = int'(in_port);
      8: if (imm < NO) begin m_port[imm] = m_acc; m_strobe[imm] = 1'b1; end
      9: m_pc = (m_pc & 'hF0) | imm;
      10: if (m_cy != 0) m_pc = (m_pc & 'hF0) | imm;
      11: if (m_zf != 0) m_pc = (m_pc & 'hF0) | imm;
      12: begin s = m_acc + imm + m_cy; m_cy = int'(s > 15); m_acc = s & 15; end
      15: m_phase = PH;
      default: ;
    endcase
    if ((op >= 1 && op <= 7) || op == 12) m_zf = int'(m_acc == 0);
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) m_reset();
      else begin
        m_strobe = '0;
        if (m_phase == PF) begin
          if (imem_ack) begin
            m_ir = int'(mem[m_pc]);
            m_pc = (m_pc + 1) % 256;
            m_phase = PE;
            wait_cnt = next_wait();
          end
        end else if (m_phase == PE) m_exec();
      end
    end
  end

  // Compare DUT against the model, then drive the memory side for the next edge
  initial begin
    logic [NO*DW-1:0] ep;
    imem_ack = 1'b0; imem_data = '0; in_port = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int p = 0; p < NO; p++) ep[p*DW +: DW] = m_port[p][DW-1:0];
        chk("req", imem_req, m_phase == PF);
        if (m_phase == PF) chk("addr", imem_addr, m_pc);
        chk("acc", acc, m_acc);
        chk("cy", cy, m_cy);
        chk("zf", zf, m_zf);
        chk("halted", halted, m_phase == PH);
        chk("out_port", out_port, ep);
        chk("out_strobe", out_strobe, m_strobe);
        for (int p = 0; p < NO; p++) if (out_strobe[p]) st_cnt[p]++;
      end
      imem_ack  = 1'b0;
      imem_data = 8'($urandom);
      if (rst && m_phase == PF) begin
        if (wait_cnt == 0) begin
          imem_ack  = 1'b1;
          imem_data = mem[m_pc];
          trace.push_back(m_pc);
        end else wait_cnt--;
      end
      in_port = 4'($urandom);
    end
  end

  task automatic do_reset();
    @(posedge clk); #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    trace.delete();
    foreach (st_cnt[p]) st_cnt[p] = 0;
  endtask

  task automatic do_release();
    @(posedge clk); #2 rst = 1'b1; #1;
  endtask

  task automatic clr_mem();
    foreach (mem[i]) mem[i] = 8'h00;
  endtask

  initial begin
    int exp_tr [5];
    clr_mem();
    #12;
    chk("rst_acc", acc, 0);        chk("rst_cy", cy, 0);
    chk("rst_zf", zf, 0);          chk("rst_out", out_port, 0);
    chk("rst_strobe", out_strobe, 0); chk("rst_halted", halted, 0);
    chk("rst_req", imem_req, 0);

    // LDI 5; ADD 0xC; HALT, zero-wait
    mem[0] = 8'h15; mem[1] = 8'h2C; mem[2] = 8'hF0;
    wait_mode = 0; do_reset(); do_release();
    chk("t1_req_first", imem_req, 1); chk("t1_addr_first", imem_addr, 0);
    repeat (5) @(posedge clk); #1 chk("t1_halt_c5", halted, 0);
    @(posedge clk); #1 chk("t1_halt_c6", halted, 1);
    chk("t1_acc", acc, 1); chk("t1_cy", cy, 1); chk("t1_zf", zf, 0);
    chk("t1_req_after", imem_req, 0);

    // Same program, three wait cycles on every fetch
    wait_mode = 3; do_reset(); do_release();
    repeat (14) @(posedge clk); #1 chk("t2_halt_c14", halted, 0);
    @(posedge clk); #1 chk("t2_halt_c15", halted, 1);
    chk("t2_acc", acc, 1); chk("t2_cy", cy, 1); chk("t2_zf", zf, 0);

    // JZ taken, JC not taken
    clr_mem();
    mem[0] = 8'h10; mem[1] = 8'hB6; mem[6] = 8'h11; mem[7] = 8'hAA; mem[8] = 8'hF0;
    wait_mode = 0; do_reset(); do_release();
    repeat (12) @(posedge clk); #1;
    exp_tr = '{0, 1, 6, 7, 8};
    chk("t3_trace_len", trace.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < trace.size()) chk($sformatf("t3_trace%0d", i), trace[i], exp_tr[i]);
    chk("t3_acc", acc, 1); chk("t3_cy", cy, 0); chk("t3_halted", halted, 1);

    // LDI 9; OUT 1; OUT 3 (dropped); HALT
    clr_mem();
    mem[0] = 8'h19; mem[1] = 8'h81; mem[2] = 8'h83; mem[3] = 8'hF0;
    do_reset(); do_release();
    repeat (10) @(posedge clk); #1;
    chk("t4_out", out_port, 8'h90);
    chk("t4_strobe1_cnt", st_cnt[1], 1);
    chk("t4_strobe0_cnt", st_cnt[0], 0);

    // PC wrap 0xFF -> 0x00 through NOPs
    clr_mem();
    do_reset(); do_release();
    repeat (510) @(posedge clk); #1 chk("t5_addr_ff", imem_addr, 8'hFF);
    repeat (2) @(posedge clk); #1 chk("t5_addr_wrap", imem_addr, 8'h00);
    chk("t5_req_wrap", imem_req, 1);

    // Reset mid-fetch drops the request at once
    mem[0] = 8'h15; mem[1] = 8'h2C; mem[2] = 8'hF0;
    wait_mode = 3; do_reset(); do_release();
    chk("t6_req_fetch", imem_req, 1);
    rst = 1'b0; #1 chk("t6_req_rst", imem_req, 0);

    // Reset during EXEC of ADD
    wait_mode = 0; do_reset(); do_release();
    repeat (3) @(posedge clk); #2 chk("t6_acc_pre", acc, 5);
    rst = 1'b0; #1;
    chk("t6_acc_rst", acc, 0); chk("t6_cy_rst", cy, 0);
    do_release();
    chk("t6_addr_rel", imem_addr, 0); chk("t6_req_rel", imem_req, 1);

    // Random programs with random fetch latency
    wait_mode = -1;
    for (int r = 0; r < 6; r++) begin
      foreach (mem[i])
        mem[i] = ($urandom_range(0, 63) == 0) ? 8'hF0
               : {4'($urandom_range(0, 14)), 4'($urandom)};
      do_reset(); do_release();
      repeat (400) @(posedge clk);
    end

    #1 $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
